// File: rtl/hienthi_pkg.sv
// Shared definitions for the multiplexed 7-segment display stage:
// active-low segment patterns ({g,f,e,d,c,b,a}), converter FSM states,
// the BCD result width and a digit-to-segment lookup.
package hienthi_pkg;

  localparam int unsigned BCD_W = 12;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LATCH
  } conv_state_e;

  function automatic logic [6:0] seg_digit(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_tuantu.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : accepted only while idle; loads bin and begins conversion
//   bin        : binary value to convert
//   busy       : high from the start edge until the result is released
//   done       : one-cycle pulse (LATCH state) while bcd holds the result
//   bcd        : {hundreds, tens, units}
import hienthi_pkg::*;

module bin2bcd_tuantu (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_e          state_q, state_d;
  logic [BCD_W+7:0]     shift_q, shift_d;
  logic [2:0]           iter_q, iter_d;
  logic                 busy_q, busy_d;
  logic [BCD_W+7:0]     adj;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    adj     = shift_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = {{BCD_W{1'b0}}, bin};
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        // Correct every BCD nibble before the shift so it carries properly.
        for (int unsigned i = 0; i < 3; i++) begin
          if (adj[8 + 4*i +: 4] >= 4'd5)
            adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4] + 4'd3;
        end
        shift_d = {adj[BCD_W+6:0], 1'b0};
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd7)
          state_d = LATCH;
      end
      LATCH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = (state_q == LATCH);
  assign bcd  = shift_q[BCD_W+7:8];

endmodule

// File: rtl/hienthi_7doan_quet.sv
// Multiplexed 4-digit common-anode 7-segment display for the up/down
// counter: shows value (000-255) on digits 0-2 and the direction (U/d)
// on digit 3.
// Ports:
//   clk, reset : board clock, asynchronous active-high reset
//   value      : counter value, re-registered twice before use
//   ud         : count direction (1 = up), re-registered twice
//   seg        : segments {g,f,e,d,c,b,a}, active-low, registered
//   dp         : decimal point, active-low, held off
//   an         : digit enables, active-low, an[0] = units, registered
//   busy       : BCD conversion in progress
import hienthi_pkg::*;

module hienthi_7doan_quet #(
  parameter int REFRESH_BITS = 18,
  parameter int BLANK_LZ     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       ud,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  logic [7:0]              v1_q, v2_q, last_q, last_d;
  logic                    u1_q, u2_q;
  logic [3:0]              d2_q, d1_q, d0_q, d2_d, d1_d, d0_d;
  logic [REFRESH_BITS-1:0] scan_q, scan_d;
  logic [6:0]              seg_q, seg_d;
  logic [3:0]              an_q, an_d;
  logic                    dp_q, dp_d;

  logic                    conv_busy, conv_done, accept;
  logic [BCD_W-1:0]        conv_bcd;
  logic [1:0]              sel;

  bin2bcd_tuantu u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .bin   (v2_q),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Converter idle doubles as the FSM IDLE qualifier for change detection.
  assign accept = !conv_busy && (v1_q == v2_q) && (v2_q != last_q);
  assign sel    = scan_q[REFRESH_BITS-1 -: 2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q   <= '0;
      v2_q   <= '0;
      u1_q   <= 1'b0;
      u2_q   <= 1'b0;
      last_q <= '0;
      d2_q   <= '0;
      d1_q   <= '0;
      d0_q   <= '0;
      scan_q <= '0;
      seg_q  <= SEG_BLANK;
      an_q   <= '1;
      dp_q   <= 1'b1;
    end else begin
      v1_q   <= value;
      v2_q   <= v1_q;
      u1_q   <= ud;
      u2_q   <= u1_q;
      last_q <= last_d;
      d2_q   <= d2_d;
      d1_q   <= d1_d;
      d0_q   <= d0_d;
      scan_q <= scan_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      dp_q   <= dp_d;
    end
  end

  always_comb begin
    last_d = accept ? v2_q : last_q;
    d2_d   = d2_q;
    d1_d   = d1_q;
    d0_d   = d0_q;
    if (conv_done) begin
      d2_d = conv_bcd[11:8];
      d1_d = conv_bcd[7:4];
      d0_d = conv_bcd[3:0];
    end
    scan_d = scan_q + REFRESH_BITS'(1);
    dp_d   = 1'b1;
  end

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    case (sel)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = seg_digit(d0_q);
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = (BLANK_LZ != 0 && d2_q == 4'd0 && d1_q == 4'd0) ? SEG_BLANK : seg_digit(d1_q);
      end
      2'd2: begin
        an_d  = 4'b1011;
        seg_d = (BLANK_LZ != 0 && d2_q == 4'd0) ? SEG_BLANK : seg_digit(d2_q);
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = u2_q ? SEG_U : SEG_D;
      end
    endcase
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = dp_q;
  assign busy = conv_busy;

endmodule

// File: doc/hienthi_7doan_quet.md
# hienthi_7doan_quet

Downstream display stage for the LED up/down counter: takes the counter's 8-bit value and the count-direction flag and shows them on a 4-digit, common-anode, multiplexed 7-segment display. The value is converted to three BCD digits (000–255) by a sequential shift-add-3 converter. Digit 3 shows the direction (`U`/`d`). All logic runs on the board clock; the counter value is treated as a slowly changing register output and is re-registered before use.

## Interface
Parameters:
- `REFRESH_BITS`, default 18: width of the scan counter. Each digit is lit for 2^(REFRESH_BITS-2) clk cycles.
- `BLANK_LZ`, default 1: when 1, blank the leading-zero hundreds and tens digits. Units are always shown.

Ports:
- `clk` in 1: board clock. Single clock domain.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `value` in 8: counter value (LED bus).
- `ud` in 1: count direction. 1 = up, 0 = down.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low. Held 1 (off).
- `an` out 4: digit enables, active-low. an[0] = units, an[3] = direction digit.
- `busy` out 1: high while a conversion is in progress.

## Operation
- Input capture: `value` → `v1` → `v2` each clk. `ud` → `u1` → `u2`.
- A value is accepted when FSM is IDLE, `v1 == v2` (stable), and `v2 != last`. On accept: `last <= v2`.
- FSM states:
  - IDLE: on accept → CONV. Load shift reg = {12'b0, v2}, iter = 0, `busy` = 1.
  - CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift left 1. iter++. After the 8th shift → LATCH.
  - LATCH: copy hundreds/tens/units into display regs `d2,d1,d0`. `busy` = 0. → IDLE.
- `value` changes during CONV/LATCH are ignored. They are re-evaluated in IDLE, so the latest stable value is always displayed eventually.
- Scan: a free-running `scan_cnt[REFRESH_BITS-1:0]`. Digit select `sel = scan_cnt[MSB:MSB-1]`.
  - sel 0–2: show d0/d1/d2.
  - sel 3: show `U` if `u2`, else `d`.
- Blanking (BLANK_LZ=1): d2 blank if 0. d1 blank if d2 == 0 and d1 == 0. A blanked digit drives seg = 7'h7F, while its `an` bit is still asserted.
- `seg`, `an`, `dp` are registered outputs.

## Timing
- Reset values: seg = 7'h7F, an = 4'hF, dp = 1, busy = 0, d2/d1/d0 = 0, last = 0, v1/v2 = 0, u1/u2 = 0, scan_cnt = 0, FSM = IDLE.
- First registered output after reset release shows digit 0 ('0') on an = 4'b1110.
- Latency from `value` change to display regs:
  - 2 edges to reach v1/v2 agreement.
  - Accept edge (enters CONV).
  - 8 CONV edges.
  - 1 LATCH edge.
  - Total: 12 clk edges from the first edge sampling the new value. `busy` is high for exactly 9 cycles.
- `seg`/`an` follow the display regs one cycle after update, within the digit period currently active.
- `ud` change appears on digit 3 three edges after it changes (2 sync stages + output reg).
- scan_cnt wraps from all-ones to 0, which returns the scan to digit 0. There are no gaps or duplicated digits.
- Reset mid-conversion: FSM → IDLE and display regs cleared. After release, the current value is re-accepted (if ≠ 0) and converted.

## Structure
- Package `hienthi_pkg`:
  - Segment constants for 0–9, `U` (7'b1000001), `d` (7'b0100001), blank (7'h7F).
  - FSM state enum IDLE/CONV/LATCH.
  - Constant for the BCD width (12).
- Sub-module `bin2bcd_tuantu`: sequential 8-bit → 3-digit BCD converter.
  - Handshake: `start` pulse, `busy`, `done` pulse with `bcd[11:0]`.
  - Holds the FSM and the shift register.
- The top contains the input sync, the change detect, the scan counter, the decode and the output regs.

## Test plan
Bench uses REFRESH_BITS=4 (4 clk per digit).
- Reset held, then released with value = 0, ud = 1 → an cycles 1110, 1101, 1011, 0111.
  - Units shows '0' (7'b1000000). Tens and hundreds are blank. Digit 3 shows `U`.
- value 0 → 255 → busy high 9 cycles. Display regs become 2/5/5 exactly 12 edges after the change. Scan shows "U255".
- value 7 with BLANK_LZ=1 → hundreds/tens seg = 7'h7F and units = 7'b1111000. With BLANK_LZ=0, shows "007".
- During CONV of 100, value changes to 42 → 100 is displayed first. Then 42 is accepted on returning to IDLE and displayed 12 edges later.
- ud toggles 1 → 0 → digit 3 changes `U` → `d` three edges later. Other digits are unchanged.
- reset asserted on the 4th CONV cycle of 200 → outputs go to reset values immediately. After release, 200 is reconverted and displayed.
